// File: rtl/res_switch_ctrl_if.sv
// ---------------------------------------------------------------------------
// res_switch_ctrl_if
// Signal bundle between the resolution-switch controller and its surroundings
// (button toggle, MMCM, pattern generator).
//
// Handshake: req_xga is a CLK-synchronous level, not a pulse. The controller
// samples it only while busy=0 (IDLE). A mismatch against xga starts a
// sequence, and busy rises on the next cycle. While busy=1, changes on req_xga
// are held off. They are looked at again on the first IDLE cycle. No ready
// signal is needed: busy is the only back-pressure.
//
//   req_xga   requested resolution, 1=XGA 0=VGA          (to controller)
//   vsync_x   active-low vsync, display-clock domain     (to controller)
//   locked    MMCM lock, asynchronous                    (to controller)
//   clk_sel   MMCM display-clock select, 1=65 MHz        (from controller)
//   xga       active resolution for the pattern gen      (from controller)
//   pat_rst   active-high pattern generator reset        (from controller)
//   blank     forces RGB to zero                         (from controller)
//   busy      high in every state except IDLE            (from controller)
//   err       sticky lock-timeout flag                   (from controller)
//   dbg_state FSM state: 0=INIT 1=IDLE 2=ARM 3=HOLD 4=SWITCH 5=WAIT_LOCK
//             6=RELEASE                                  (from controller)
// ---------------------------------------------------------------------------
interface res_switch_ctrl_if;
  logic       req_xga;
  logic       vsync_x;
  logic       locked;
  logic       clk_sel;
  logic       xga;
  logic       pat_rst;
  logic       blank;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  modport master (
    output req_xga, vsync_x, locked,
    input  clk_sel, xga, pat_rst, blank, busy, err, dbg_state
  );

  modport slave (
    input  req_xga, vsync_x, locked,
    output clk_sel, xga, pat_rst, blank, busy, err, dbg_state
  );
endinterface

// File: rtl/res_switch_ctrl.sv
// ---------------------------------------------------------------------------
// res_switch_ctrl
// Sequences a VGA <-> XGA resolution change in the 100 MHz system domain.
// The sequence is: blank, wait for vsync, hold the pattern generator in
// reset, switch the MMCM clock select, wait for lock, release reset, and
// un-blank on the next frame. The same path performs the power-up bring-up.
// In that case reset is held until the first lock.
//
// Ports:
//   clk    system clock, 100 MHz
//   rst_n  asynchronous active-low reset
//   bus    res_switch_ctrl_if.slave (see interface header for signals)
//
// Parameters (all in clk cycles):
//   RST_HOLD      pattern reset held in HOLD before clk_sel changes
//   LOCK_WAIT     time after a clk_sel change during which lock is ignored
//   LOCK_TIMEOUT  time in INIT/WAIT_LOCK before err is raised
//   VS_TIMEOUT    maximum wait for a vsync falling edge
// ---------------------------------------------------------------------------
module res_switch_ctrl #(
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned LOCK_WAIT    = 64,
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned VS_TIMEOUT   = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  res_switch_ctrl_if.slave bus
);

  localparam int unsigned MAX_AB = (RST_HOLD > LOCK_WAIT) ? RST_HOLD : LOCK_WAIT;
  localparam int unsigned MAX_CD = (LOCK_TIMEOUT > VS_TIMEOUT) ? LOCK_TIMEOUT : VS_TIMEOUT;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] C_RH_M1   = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] C_LW_M1   = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] C_VS_M1   = CW'(VS_TIMEOUT - 1);
  localparam logic [CW-1:0] C_LOCK_TO = CW'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_ARM       = 3'd2,
    S_HOLD      = 3'd3,
    S_SWITCH    = 3'd4,
    S_WAIT_LOCK = 3'd5,
    S_RELEASE   = 3'd6
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          tgt;

  // Two-flop synchronisers. vs_d is a third flop that is used only for edge
  // detection.
  logic vs_m, vs_s, vs_d;
  logic lock_m, lock_s;
  logic vs_fall;

  logic clk_sel_q, xga_q, pat_rst_q, blank_q, busy_q, err_q;

  assign vs_fall = vs_d & ~vs_s;

  // The counter never wraps. In INIT and WAIT_LOCK it is additionally held at
  // LOCK_TIMEOUT below.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_m      <= 1'b0;
      vs_s      <= 1'b0;
      vs_d      <= 1'b0;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      state     <= S_INIT;
      cnt       <= '0;
      tgt       <= 1'b0;
      clk_sel_q <= 1'b0;
      xga_q     <= 1'b0;
      pat_rst_q <= 1'b1;
      blank_q   <= 1'b1;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      vs_m   <= bus.vsync_x;
      vs_s   <= vs_m;
      vs_d   <= vs_s;
      lock_m <= bus.locked;
      lock_s <= lock_m;

      case (state)
        S_INIT: begin
          if (lock_s) begin
            state     <= S_RELEASE;
            cnt       <= '0;
            pat_rst_q <= 1'b0;
            xga_q     <= clk_sel_q;
          end else begin
            if (cnt != C_LOCK_TO) cnt <= cnt_inc;
            // err appears on the same cycle that cnt reaches LOCK_TIMEOUT.
            if (cnt_inc >= C_LOCK_TO) err_q <= 1'b1;
          end
        end

        S_IDLE: begin
          if (!lock_s) begin
            state     <= S_INIT;
            cnt       <= '0;
            pat_rst_q <= 1'b1;
            blank_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else if (bus.req_xga != xga_q) begin
            state   <= S_ARM;
            cnt     <= '0;
            tgt     <= bus.req_xga;
            blank_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        // A vsync edge seen during the IDLE cycle that starts the request is
        // not counted here. Only edges seen while already in ARM count.
        S_ARM: begin
          if (vs_fall || cnt == C_VS_M1) begin
            state     <= S_HOLD;
            cnt       <= '0;
            pat_rst_q <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // clk_sel moves on the transition into SWITCH, so it is already valid
        // in the first SWITCH cycle.
        S_HOLD: begin
          if (cnt == C_RH_M1) begin
            state     <= S_SWITCH;
            cnt       <= '0;
            clk_sel_q <= tgt;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Lock is ignored here. The MMCM may still report the old lock.
        S_SWITCH: begin
          if (cnt == C_LW_M1) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state     <= S_RELEASE;
            cnt       <= '0;
            pat_rst_q <= 1'b0;
            xga_q     <= clk_sel_q;
          end else begin
            if (cnt != C_LOCK_TO) cnt <= cnt_inc;
            if (cnt_inc >= C_LOCK_TO) err_q <= 1'b1;
          end
        end

        S_RELEASE: begin
          if (!lock_s) begin
            state     <= S_INIT;
            cnt       <= '0;
            pat_rst_q <= 1'b1;
            blank_q   <= 1'b1;
          end else if (vs_fall || cnt == C_VS_M1) begin
            state   <= S_IDLE;
            cnt     <= '0;
            blank_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state     <= S_INIT;
          cnt       <= '0;
          pat_rst_q <= 1'b1;
          blank_q   <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.clk_sel   = clk_sel_q;
  assign bus.xga       = xga_q;
  assign bus.pat_rst   = pat_rst_q;
  assign bus.blank     = blank_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_res_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_res_switch_ctrl
// Self-checking bench for res_switch_ctrl with short timing parameters.
// Expected event times are derived from the recorded vsync fall times. An
// input that is driven after clock edge k acts on the FSM at edge k+3 (two
// synchroniser flops plus the edge-detect flop). Each sequence step then
// follows from the state durations.
// ---------------------------------------------------------------------------
module tb_res_switch_ctrl;
  localparam int RST_HOLD  = 4;
  localparam int LOCK_WAIT = 8;
  localparam int LOCK_TO   = 100;
  localparam int VS_TO     = 50;

  // Debug state encoding documented in the interface header.
  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_SWITCH    = 3'd4;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd5;
  localparam logic [2:0] ST_RELEASE   = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_switch_ctrl_if bus();

  res_switch_ctrl #(
    .RST_HOLD    (RST_HOLD),
    .LOCK_WAIT   (LOCK_WAIT),
    .LOCK_TIMEOUT(LOCK_TO),
    .VS_TIMEOUT  (VS_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs are driven, and outputs are sampled, 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- vsync generator ----------------
  logic vs_en     = 1'b0;
  int   vs_period = 10;
  int   vs_age    = 0;
  int   falls[$];

  initial begin
    bus.vsync_x = 1'b1;
    forever begin
      @(negedge clk);
      if (!vs_en) begin
        bus.vsync_x = 1'b1;
        vs_age      = 0;
      end else begin
        vs_age++;
        if (vs_age >= vs_period) begin
          bus.vsync_x = 1'b0;
          falls.push_back(cyc);
          vs_age    = 0;
          vs_period = $urandom_range(24, 84);
        end else if (vs_age == 4) begin
          bus.vsync_x = 1'b1;
        end
      end
    end
  end

  // Reference: ARM and RELEASE last until the first vsync fall that reaches
  // the FSM after the state is entered, or until VS_TO cycles have passed.
  // The function returns the cycle in which the next state becomes visible.
  function automatic int exp_vs_exit(input int entry);
    int best;
    best = entry + VS_TO;
    foreach (falls[i])
      if (falls[i] + 3 >= entry + 1 && falls[i] + 3 < best) best = falls[i] + 3;
    return best;
  endfunction

  // ---------------- output event monitor ----------------
  int   ev_blank_rise = 0, ev_prst_rise = 0, ev_prst_fall = 0, ev_cs = 0, ev_busy_fall = 0;
  logic p_blank = 1'b1, p_prst = 1'b1, p_cs = 1'b0, p_busy = 1'b1;

  always @(negedge clk) begin
    if (bus.blank && !p_blank)   ev_blank_rise = cyc;
    if (bus.pat_rst && !p_prst)  ev_prst_rise  = cyc;
    if (!bus.pat_rst && p_prst)  ev_prst_fall  = cyc;
    if (bus.clk_sel != p_cs)     ev_cs         = cyc;
    if (!bus.busy && p_busy)     ev_busy_fall  = cyc;
    p_blank = bus.blank;
    p_prst  = bus.pat_rst;
    p_cs    = bus.clk_sel;
    p_busy  = bus.busy;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_state(input logic [2:0] st, input int lim, input string name);
    for (int i = 0; i < lim && bus.dbg_state != st; i++) tick();
    check(name, bus.dbg_state, st);
  endtask

  task automatic wait_busy(input logic val, input int lim, input string name);
    for (int i = 0; i < lim && bus.busy != val; i++) tick();
    check(name, bus.busy, val);
  endtask

  task automatic wait_cs(input logic val, input int lim, input string name);
    for (int i = 0; i < lim && bus.clk_sel != val; i++) tick();
    check(name, bus.clk_sel, val);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic req;
    logic vs_on;
    logic exp_xga;
    logic exp_cs;
    logic exp_seq;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int t, r, h, s, w, rel, a, lat, bad;
    logic cur;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.req_xga = 1'b0;
    bus.locked  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_state", bus.dbg_state, ST_INIT);
    check("rst_clk_sel", bus.clk_sel, 0);
    check("rst_xga", bus.xga, 0);
    check("rst_pat_rst", bus.pat_rst, 1);
    check("rst_blank", bus.blank, 1);
    check("rst_busy", bus.busy, 1);
    check("rst_err", bus.err, 0);

    // T1: bring-up with lock low for 100 cycles
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (!(bus.pat_rst && bus.blank)) bad++;
    end
    check("t1_held_in_reset", bad, 0);
    bus.locked = 1'b1;
    t = cyc;
    for (int i = 0; i < 6 && bus.dbg_state != ST_RELEASE; i++) tick();
    lat = cyc - t;
    check("t1_release_latency_ok", (lat >= 2 && lat <= 4), 1);
    check("t1_pat_rst", bus.pat_rst, 0);
    check("t1_xga", bus.xga, 0);
    // INIT has spent LOCK_TO cycles without lock, so the timeout flag is up.
    check("t1_init_timeout_err", bus.err, 1);
    rel       = cyc;
    vs_period = 10;
    vs_en     = 1'b1;
    wait_busy(0, 100, "t1_idle");
    check("t1_idle_cycle", ev_busy_fall, exp_vs_exit(rel));
    check("t1_blank", bus.blank, 0);

    // Reset clears err
    rst_n = 1'b0;
    #1;
    check("rst2_err", bus.err, 0);
    check("rst2_state", bus.dbg_state, ST_INIT);
    tick();
    rst_n = 1'b1;
    wait_state(ST_IDLE, 200, "rst2_idle");
    check("rst2_xga", bus.xga, 0);

    // T2: VGA -> XGA with lock dropped for 20 cycles after the switch
    repeat (3) tick();
    bus.req_xga = 1'b1;
    r = cyc;
    tick();
    check("t2_blank_next", bus.blank, 1);
    check("t2_busy_next", bus.busy, 1);
    wait_state(ST_HOLD, 100, "t2_hold");
    h = cyc;
    check("t2_pat_rst", bus.pat_rst, 1);
    check("t2_hold_cycle", h, exp_vs_exit(r + 1));
    wait_cs(1, 10, "t2_clk_sel");
    check("t2_clk_sel_cycle", cyc, h + RST_HOLD);
    bus.locked = 1'b0;
    repeat (20) tick();
    check("t2_wait_lock", bus.dbg_state, ST_WAIT_LOCK);
    bus.locked = 1'b1;
    t = cyc;
    tick();
    check("t2_xga_not_yet", bus.xga, 0);
    for (int i = 0; i < 5 && !bus.xga; i++) tick();
    lat = cyc - t;
    check("t2_xga_latency_ok", (lat >= 2 && lat <= 4), 1);
    rel = cyc;
    wait_busy(0, 200, "t2_done");
    check("t2_idle_cycle", ev_busy_fall, exp_vs_exit(rel));
    check("t2_blank_off", bus.blank, 0);
    check("t2_final_xga", bus.xga, 1);

    // Lock lost in IDLE
    bus.locked = 1'b0;
    wait_state(ST_INIT, 6, "ld_init");
    check("ld_pat_rst", bus.pat_rst, 1);
    check("ld_blank", bus.blank, 1);
    check("ld_xga_kept", bus.xga, 1);
    check("ld_clk_sel_kept", bus.clk_sel, 1);
    bus.locked = 1'b1;
    wait_state(ST_IDLE, 200, "ld_idle");
    check("ld_xga_after", bus.xga, 1);

    // T3: vsync held high, both vsync waits time out
    vs_en = 1'b0;
    repeat (8) tick();
    bus.req_xga = 1'b0;
    r = cyc;
    tick();
    wait_state(ST_HOLD, 80, "t3_hold");
    check("t3_arm_timeout", cyc - (r + 1), VS_TO);
    wait_busy(0, 200, "t3_done");
    check("t3_release_timeout", ev_busy_fall - ev_prst_fall, VS_TO);
    check("t3_xga", bus.xga, 0);

    // Table of requests
    for (int i = 0; i < 6; i++) begin
      vs_en = tbl[i].vs_on;
      repeat (6) tick();
      bus.req_xga = tbl[i].req;
      if (tbl[i].exp_seq) begin
        tick();
        check("tbl_busy", bus.busy, 1);
        wait_busy(0, 300, "tbl_done");
      end else begin
        bad = 0;
        repeat (6) begin
          tick();
          if (bus.busy) bad++;
        end
        check("tbl_no_seq", bad, 0);
      end
      check("tbl_xga", bus.xga, tbl[i].exp_xga);
      check("tbl_clk_sel", bus.clk_sel, tbl[i].exp_cs);
      check("tbl_blank", bus.blank, 0);
    end

    // T5: request withdrawn during HOLD
    vs_en = 1'b1;
    bus.req_xga = 1'b1;
    tick();
    wait_state(ST_HOLD, 100, "t5_hold");
    bus.req_xga = 1'b0;
    wait_busy(0, 300, "t5_first_done");
    check("t5_first_xga", bus.xga, 1);
    check("t5_first_clk_sel", bus.clk_sel, 1);
    tick();
    check("t5_restart_busy", bus.busy, 1);
    check("t5_restart_blank", bus.blank, 1);
    wait_busy(0, 300, "t5_second_done");
    check("t5_second_xga", bus.xga, 0);
    check("t5_second_clk_sel", bus.clk_sel, 0);

    // T4: lock timeout in WAIT_LOCK
    bus.req_xga = 1'b1;
    tick();
    wait_cs(1, 200, "t4_switch");
    bus.locked = 1'b0;
    wait_state(ST_WAIT_LOCK, 20, "t4_wait_lock");
    w = cyc;
    repeat (LOCK_TO - 1) tick();
    check("t4_err_before", bus.err, 0);
    tick();
    check("t4_err_set", bus.err, 1);
    check("t4_busy", bus.busy, 1);
    check("t4_still_waiting", bus.dbg_state, ST_WAIT_LOCK);
    bus.locked = 1'b1;
    wait_busy(0, 300, "t4_done");
    check("t4_err_sticky", bus.err, 1);
    check("t4_xga", bus.xga, 1);

    // T6: reset during SWITCH with clk_sel=1
    bus.req_xga = 1'b0;
    tick();
    wait_busy(0, 300, "t6_back_vga");
    bus.req_xga = 1'b1;
    tick();
    wait_cs(1, 200, "t6_switch_cs");
    repeat (2) tick();
    check("t6_in_switch", bus.dbg_state, ST_SWITCH);
    rst_n = 1'b0;
    #1;
    check("t6_clk_sel", bus.clk_sel, 0);
    check("t6_pat_rst", bus.pat_rst, 1);
    check("t6_blank", bus.blank, 1);
    check("t6_err", bus.err, 0);
    check("t6_state", bus.dbg_state, ST_INIT);
    check("t6_xga", bus.xga, 0);
    bus.req_xga = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_state(ST_IDLE, 200, "t6_recover");
    check("t6_recover_xga", bus.xga, 0);

    // Random requests against the timing reference
    cur = 1'b0;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 30)) tick();
      cur = ~cur;
      bus.req_xga = cur;
      r = cyc;
      tick();
      wait_busy(0, 400, "rnd_done");
      a   = r + 1;
      h   = exp_vs_exit(a);
      s   = h + RST_HOLD;
      w   = s + LOCK_WAIT;
      rel = w + 1;
      check("rnd_arm", ev_blank_rise, a);
      check("rnd_hold", ev_prst_rise, h);
      check("rnd_switch", ev_cs, s);
      check("rnd_release", ev_prst_fall, rel);
      check("rnd_idle", ev_busy_fall, exp_vs_exit(rel));
      check("rnd_xga", bus.xga, cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
